// File: rtl/ethernet_axi_slave_mem.sv
// ethernet_axi_slave_mem
// AXI4 memory-mapped slave that closes the loop on the ethernet IP's burst
// master. It serves INCR bursts of 4-byte beats from an internal
// word-addressed memory. One transaction is in flight at a time. When write
// and read requests arrive together, the grant alternates between the two
// sides.
module ethernet_axi_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 10
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  // write address channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  // write response channel
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int WADDR_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam int DEPTH   = 1 << WADDR_W;
  localparam int STRB_W  = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW_ACK,
    ST_WDATA,
    ST_WRESP,
    ST_AR_ACK,
    ST_RDATA
  } state_e;

  state_e                        state_q;
  logic                          awready_q;
  logic                          wready_q;
  logic                          bvalid_q;
  logic [1:0]                    bresp_q;
  logic                          arready_q;
  logic                          rvalid_q;
  logic [C_S_AXI_ID_WIDTH-1:0]   id_q;
  logic [WADDR_W-1:0]            addr_q;
  logic [7:0]                    len_q;
  logic [7:0]                    cnt_q;
  // Set when the read side was granted most recently; a tie goes to the other side.
  logic                          last_rd_q;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];

  logic w_beat;
  logic r_beat;
  logic cnt_at_len;

  // The address LSBs are ignored because every beat is a full 4-byte word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // wready_q is high only in WDATA and rvalid_q only in RDATA, so each of
  // these terms already implies the corresponding state.
  assign w_beat     = wready_q & S_AXI_WVALID;
  assign r_beat     = rvalid_q & S_AXI_RREADY;
  assign cnt_at_len = (cnt_q == len_q);

  // Transaction FSM: arbitration, address/ID capture, beat counting, registered handshakes.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge, whatever order the
  // statements appear in.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= ST_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      last_rd_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (S_AXI_AWVALID && (!S_AXI_ARVALID || last_rd_q)) begin
            state_q   <= ST_AW_ACK;
            awready_q <= 1'b1;
            last_rd_q <= 1'b0;
          end else if (S_AXI_ARVALID) begin
            state_q   <= ST_AR_ACK;
            arready_q <= 1'b1;
            last_rd_q <= 1'b1;
          end
        end

        // A master cannot withdraw AWVALID once it is raised, so the
        // request sampled in IDLE is still present here.
        ST_AW_ACK: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          id_q      <= S_AXI_AWID;
          addr_q    <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
          len_q     <= S_AXI_AWLEN;
          cnt_q     <= '0;
          state_q   <= ST_WDATA;
        end

        ST_WDATA: begin
          if (w_beat) begin
            addr_q <= addr_q + WADDR_W'(1);
            cnt_q  <= cnt_q + 8'd1;
            // The burst ends at whichever comes first, WLAST or the
            // programmed length. If the two disagree, the response is
            // SLVERR.
            if (S_AXI_WLAST || cnt_at_len) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (S_AXI_WLAST != cnt_at_len) ? RESP_SLVERR : RESP_OKAY;
              state_q  <= ST_WRESP;
            end
          end
        end

        ST_WRESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            state_q  <= ST_IDLE;
          end
        end

        ST_AR_ACK: begin
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          id_q      <= S_AXI_ARID;
          addr_q    <= S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
          len_q     <= S_AXI_ARLEN;
          cnt_q     <= '0;
          state_q   <= ST_RDATA;
        end

        ST_RDATA: begin
          if (r_beat) begin
            addr_q <= addr_q + WADDR_W'(1);
            cnt_q  <= cnt_q + 8'd1;
            if (cnt_at_len) begin
              rvalid_q <= 1'b0;
              state_q  <= ST_IDLE;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Byte-enabled write into the word memory on every accepted W beat.
  // NOTE: the memory array has no reset. Its contents survive ARESETN, and
  // leaving the reset off lets it map onto plain RAM.
  always_ff @(posedge ACLK) begin
    if (w_beat) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_WSTRB[b]) begin
          mem[addr_q][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_BID     = id_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RID     = id_q;
  assign S_AXI_RRESP   = RESP_OKAY;
  // Read data comes straight from the registered word address. It is forced
  // to zero while no beat is offered, and it stays stable while the master
  // stalls.
  assign S_AXI_RDATA   = rvalid_q ? mem[addr_q] : '0;
  assign S_AXI_RLAST   = rvalid_q & cnt_at_len;

endmodule

// File: tb/tb_ethernet_axi_slave_mem.sv
// Self-checking bench for ethernet_axi_slave_mem.
// The reference model is a plain word array updated from the AXI rules
// (byte strobes, INCR addressing, wrap at the top word, early or late
// WLAST). Burst responses and read data are compared against this model.
`timescale 1ns/1ps
module tb_ethernet_axi_slave_mem;

  localparam int IDW   = 1;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 256;
  localparam int LIMIT = 2000;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [IDW-1:0]  S_AXI_AWID, S_AXI_ARID, S_AXI_BID, S_AXI_RID;
  logic [AW-1:0]   S_AXI_AWADDR, S_AXI_ARADDR;
  logic [7:0]      S_AXI_AWLEN, S_AXI_ARLEN;
  logic            S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic [DW-1:0]   S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]      S_AXI_WSTRB;
  logic            S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP, S_AXI_RRESP;
  logic            S_AXI_BVALID, S_AXI_BREADY;
  logic            S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;

  always #5 clk = ~clk;

  ethernet_axi_slave_mem #(
    .C_S_AXI_ID_WIDTH  (IDW),
    .C_S_AXI_DATA_WIDTH(DW),
    .C_S_AXI_ADDR_WIDTH(AW)
  ) dut (
    .ACLK         (clk),
    .ARESETN      (rst_n),
    .S_AXI_AWID   (S_AXI_AWID),
    .S_AXI_AWADDR (S_AXI_AWADDR),
    .S_AXI_AWLEN  (S_AXI_AWLEN),
    .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA  (S_AXI_WDATA),
    .S_AXI_WSTRB  (S_AXI_WSTRB),
    .S_AXI_WLAST  (S_AXI_WLAST),
    .S_AXI_WVALID (S_AXI_WVALID),
    .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BID    (S_AXI_BID),
    .S_AXI_BRESP  (S_AXI_BRESP),
    .S_AXI_BVALID (S_AXI_BVALID),
    .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARID   (S_AXI_ARID),
    .S_AXI_ARADDR (S_AXI_ARADDR),
    .S_AXI_ARLEN  (S_AXI_ARLEN),
    .S_AXI_ARVALID(S_AXI_ARVALID),
    .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RID    (S_AXI_RID),
    .S_AXI_RDATA  (S_AXI_RDATA),
    .S_AXI_RRESP  (S_AXI_RRESP),
    .S_AXI_RLAST  (S_AXI_RLAST),
    .S_AXI_RVALID (S_AXI_RVALID),
    .S_AXI_RREADY (S_AXI_RREADY)
  );

  int errors = 0;
  int checks = 0;
  int timeouts = 0;

  // Reference memory and per-transaction observations
  logic [31:0]    model_mem [DEPTH];
  logic [31:0]    wr_data_q [$];
  logic [3:0]     wr_strb_q [$];
  logic [31:0]    rd_data_q [$];
  logic           rd_last_q [$];
  logic [IDW-1:0] r_id_seen;
  logic [1:0]     b_resp;
  logic [IDW-1:0] b_id;
  logic           aw_other, ar_other, wready_after, b_after, r_first, r_after;
  int             aw_lat, ar_lat, w_first, b_lat, bvalid_hold, stall_bad;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic model_write(input logic [7:0] word, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) model_mem[word][8*b +: 8] = data[8*b +: 8];
  endtask

  // Returns -1 when the captured burst matches the model, -2 for a wrong beat count, else the first bad beat.
  function automatic int read_mismatch(input logic [9:0] addr, input int len);
    logic [7:0] w;
    if (rd_data_q.size() != len + 1) return -2;
    w = addr[9:2];
    for (int i = 0; i <= len; i++) begin
      if (rd_data_q[i] !== model_mem[w] || rd_last_q[i] !== (i == len)) return i;
      w++;
    end
    return -1;
  endfunction

  // Write burst: beats come from wr_data_q/wr_strb_q. wlast_idx is the beat carrying WLAST (-1 means none).
  task automatic write_burst(input logic [IDW-1:0] id, input logic [9:0] addr, input int len,
                             input int wlast_idx, input int bready_delay);
    int nbeats, n;
    logic [7:0] word;
    nbeats = (wlast_idx >= 0 && wlast_idx < len) ? wlast_idx + 1 : len + 1;
    S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = 8'(len); S_AXI_AWVALID = 1'b1;
    aw_lat = 0;
    while (S_AXI_AWREADY !== 1'b1 && aw_lat < LIMIT) begin @(negedge clk); aw_lat++; end
    if (aw_lat >= LIMIT) timeouts++;
    aw_other = S_AXI_ARREADY;
    @(negedge clk);
    S_AXI_AWVALID = 1'b0;
    word = addr[9:2];
    w_first = -1;
    for (int i = 0; i < nbeats; i++) begin
      S_AXI_WDATA = wr_data_q[i]; S_AXI_WSTRB = wr_strb_q[i];
      S_AXI_WLAST = (i == wlast_idx); S_AXI_WVALID = 1'b1;
      n = 0;
      while (S_AXI_WREADY !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
      if (n >= LIMIT) timeouts++;
      if (i == 0) w_first = n;
      model_write(word, wr_data_q[i], wr_strb_q[i]);
      word++;
      @(negedge clk);
    end
    S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
    wready_after = S_AXI_WREADY;
    b_lat = 0;
    while (S_AXI_BVALID !== 1'b1 && b_lat < LIMIT) begin @(negedge clk); b_lat++; end
    if (b_lat >= LIMIT) timeouts++;
    bvalid_hold = 0;
    for (int i = 0; i < bready_delay; i++) begin
      if (S_AXI_BVALID === 1'b1) bvalid_hold++;
      @(negedge clk);
    end
    S_AXI_BREADY = 1'b1;
    b_resp = S_AXI_BRESP; b_id = S_AXI_BID;
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
    b_after = S_AXI_BVALID;
  endtask

  // Read burst: rmode 0 = RREADY always high, 1 = toggles 1/0 per cycle, 2 = random.
  task automatic read_burst(input logic [IDW-1:0] id, input logic [9:0] addr, input int len, input int rmode);
    int beats, guard;
    logic rr, stalled, hold_l;
    logic [31:0] hold_d;
    rd_data_q.delete(); rd_last_q.delete();
    stall_bad = 0;
    S_AXI_ARID = id; S_AXI_ARADDR = addr; S_AXI_ARLEN = 8'(len); S_AXI_ARVALID = 1'b1;
    ar_lat = 0;
    while (S_AXI_ARREADY !== 1'b1 && ar_lat < LIMIT) begin @(negedge clk); ar_lat++; end
    if (ar_lat >= LIMIT) timeouts++;
    ar_other = S_AXI_AWREADY;
    @(negedge clk);
    S_AXI_ARVALID = 1'b0;
    r_first = S_AXI_RVALID;
    beats = 0; guard = 0; stalled = 1'b0; hold_d = '0; hold_l = 1'b0;
    while (beats <= len && guard < LIMIT) begin
      rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
      S_AXI_RREADY = rr;
      if (S_AXI_RVALID === 1'b1) begin
        if (stalled && (S_AXI_RDATA !== hold_d || S_AXI_RLAST !== hold_l)) stall_bad++;
        if (rr) begin
          rd_data_q.push_back(S_AXI_RDATA); rd_last_q.push_back(S_AXI_RLAST);
          r_id_seen = S_AXI_RID; beats++; stalled = 1'b0;
        end else begin
          stalled = 1'b1; hold_d = S_AXI_RDATA; hold_l = S_AXI_RLAST;
        end
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= LIMIT) timeouts++;
    S_AXI_RREADY = 1'b0;
    r_after = S_AXI_RVALID;
  endtask

  task automatic load_beats(input int n, input logic random_strb);
    wr_data_q.delete(); wr_strb_q.delete();
    for (int i = 0; i < n; i++) begin
      wr_data_q.push_back($urandom);
      wr_strb_q.push_back(random_strb ? 4'($urandom_range(0, 15)) : 4'hF);
    end
  endtask

  task automatic test_reset();
    logic [47:0] outs;
    repeat (3) @(negedge clk);
    outs = {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RLAST,
            S_AXI_BRESP, S_AXI_RRESP, S_AXI_BID, S_AXI_RID, S_AXI_RDATA, 6'b0};
    checks++;
    if (outs !== 48'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", outs); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (S_AXI_RDATA !== 32'h0) begin errors++; $display("FAIL rdata_idle: got %h expected 0", S_AXI_RDATA); end
  endtask

  // One 256-beat burst defines every word, so all later reads have known contents.
  task automatic test_fill();
    load_beats(DEPTH, 1'b0);
    write_burst(1'b0, 10'h000, 255, 255, 0);
    checks++;
    if (b_resp !== 2'b00) begin errors++; $display("FAIL fill_bresp: got %b expected 00", b_resp); end
  endtask

  task automatic test_single();
    int m;
    wr_data_q = '{32'hDEADBEEF}; wr_strb_q = '{4'hF};
    write_burst(1'b1, 10'h010, 0, 0, 0);
    checks++;
    if (aw_lat !== 1) begin errors++; $display("FAIL single_aw_latency: got %0d expected 1", aw_lat); end
    checks++;
    if (w_first !== 0) begin errors++; $display("FAIL single_wready_latency: got %0d expected 0", w_first); end
    checks++;
    if (b_lat !== 0 || wready_after !== 1'b0) begin
      errors++; $display("FAIL single_b_timing: b_lat=%0d wready_after=%b expected 0/0", b_lat, wready_after);
    end
    checks++;
    if (b_resp !== 2'b00 || b_id !== 1'b1) begin
      errors++; $display("FAIL single_bresp_bid: got %b/%b expected 00/1", b_resp, b_id);
    end
    checks++;
    if (b_after !== 1'b0) begin errors++; $display("FAIL single_bvalid_drop: got %b expected 0", b_after); end
    read_burst(1'b1, 10'h010, 0, 0);
    checks++;
    if (ar_lat !== 1 || r_first !== 1'b1) begin
      errors++; $display("FAIL single_r_latency: ar_lat=%0d r_first=%b expected 1/1", ar_lat, r_first);
    end
    m = read_mismatch(10'h010, 0);
    checks++;
    if (m !== -1 || rd_data_q[0] !== 32'hDEADBEEF || rd_last_q[0] !== 1'b1) begin
      errors++; $display("FAIL single_rdata: bad beat=%0d expected -1 (DEADBEEF with RLAST)", m);
    end
    checks++;
    if (r_id_seen !== 1'b1 || r_after !== 1'b0) begin
      errors++; $display("FAIL single_rid_end: rid=%b rvalid_after=%b expected 1/0", r_id_seen, r_after);
    end
  endtask

  task automatic test_burst_strb();
    logic [31:0] exp_d [4];
    logic [31:0] got_d;
    logic [3:0] got_l;
    exp_d = '{32'h1, 32'h2, 32'hFFFF0003, 32'h4};
    wr_data_q = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    wr_strb_q = '{4'hF, 4'hF, 4'hF, 4'hF};
    write_burst(1'b0, 10'h020, 3, 3, 0);
    wr_data_q = '{32'h1, 32'h2, 32'h3, 32'h4};
    wr_strb_q = '{4'hF, 4'hF, 4'h3, 4'hF};
    write_burst(1'b0, 10'h020, 3, 3, 0);
    checks++;
    if (b_resp !== 2'b00) begin errors++; $display("FAIL burst_bresp: got %b expected 00", b_resp); end
    read_burst(1'b0, 10'h020, 3, 0);
    got_l = 4'h0;
    for (int i = 0; i < 4; i++) begin
      got_d = (i < rd_data_q.size()) ? rd_data_q[i] : 32'hX;
      got_l[i] = (i < rd_last_q.size()) ? rd_last_q[i] : 1'bX;
      checks++;
      if (got_d !== exp_d[i]) begin
        errors++; $display("FAIL burst_beat%0d: got %h expected %h", i, got_d, exp_d[i]);
      end
    end
    checks++;
    if (got_l !== 4'b1000) begin errors++; $display("FAIL burst_rlast: got %b expected 1000", got_l); end
  endtask

  task automatic test_arbitration();
    int m;
    // Tie with read served last (as after the previous test): write wins, then the held read.
    for (int t = 0; t < 2; t++) begin
      S_AXI_ARID = 1'b1; S_AXI_ARADDR = 10'h044; S_AXI_ARLEN = 8'd0; S_AXI_ARVALID = 1'b1;
      load_beats(1, 1'b0);
      write_burst(1'b0, 10'h044, 0, 0, 0);
      checks++;
      if (aw_lat !== 1 || aw_other !== 1'b0) begin
        errors++; $display("FAIL tie%0d_write_first: aw_lat=%0d arready=%b expected 1/0", t, aw_lat, aw_other);
      end
      read_burst(1'b1, 10'h044, 0, 0);
      m = read_mismatch(10'h044, 0);
      checks++;
      if (ar_lat !== 1 || m !== -1) begin
        errors++; $display("FAIL tie%0d_read_second: ar_lat=%0d bad beat=%0d expected 1/-1", t, ar_lat, m);
      end
    end
    // A lone write makes write the last served side, so the next tie goes to read.
    load_beats(1, 1'b0);
    write_burst(1'b0, 10'h048, 0, 0, 0);
    load_beats(1, 1'b0);
    S_AXI_AWID = 1'b0; S_AXI_AWADDR = 10'h04C; S_AXI_AWLEN = 8'd0; S_AXI_AWVALID = 1'b1;
    read_burst(1'b0, 10'h048, 0, 0);
    m = read_mismatch(10'h048, 0);
    checks++;
    if (ar_lat !== 1 || ar_other !== 1'b0 || m !== -1) begin
      errors++; $display("FAIL tie_read_first: ar_lat=%0d awready=%b bad=%0d expected 1/0/-1", ar_lat, ar_other, m);
    end
    write_burst(1'b0, 10'h04C, 0, 0, 0);
    checks++;
    if (aw_lat !== 1 || b_resp !== 2'b00) begin
      errors++; $display("FAIL tie_write_second: aw_lat=%0d bresp=%b expected 1/00", aw_lat, b_resp);
    end
  endtask

  task automatic test_wlast_errors();
    int m;
    load_beats(2, 1'b0);
    write_burst(1'b1, 10'h080, 3, 1, 0);
    checks++;
    if (b_resp !== 2'b10 || b_id !== 1'b1) begin
      errors++; $display("FAIL early_wlast: bresp/bid got %b/%b expected 10/1", b_resp, b_id);
    end
    read_burst(1'b0, 10'h080, 3, 0);
    m = read_mismatch(10'h080, 3);
    checks++;
    if (m !== -1) begin errors++; $display("FAIL early_wlast_store: bad beat=%0d expected -1", m); end
    load_beats(2, 1'b0);
    write_burst(1'b0, 10'h0A0, 1, -1, 0);
    checks++;
    if (b_resp !== 2'b10) begin errors++; $display("FAIL missing_wlast: bresp got %b expected 10", b_resp); end
    read_burst(1'b0, 10'h0A0, 1, 0);
    m = read_mismatch(10'h0A0, 1);
    checks++;
    if (m !== -1) begin errors++; $display("FAIL missing_wlast_store: bad beat=%0d expected -1", m); end
    load_beats(3, 1'b0);
    write_burst(1'b0, 10'h0B0, 2, 2, 0);
    checks++;
    if (b_resp !== 2'b00) begin errors++; $display("FAIL error_cleared: bresp got %b expected 00", b_resp); end
  endtask

  task automatic test_backpressure();
    int m;
    load_beats(4, 1'b1);
    write_burst(1'b1, 10'h0C0, 3, 3, 5);
    checks++;
    if (bvalid_hold !== 5 || b_resp !== 2'b00 || b_after !== 1'b0) begin
      errors++; $display("FAIL bready_delay: hold=%0d bresp=%b after=%b expected 5/00/0", bvalid_hold, b_resp, b_after);
    end
    read_burst(1'b0, 10'h0C0, 7, 1);
    m = read_mismatch(10'h0C0, 7);
    checks++;
    if (stall_bad !== 0 || m !== -1) begin
      errors++; $display("FAIL rready_toggle: unstable=%0d bad beat=%0d expected 0/-1", stall_bad, m);
    end
  endtask

  task automatic test_wrap_reset();
    int m, n;
    wr_data_q = '{32'hA5A5_0001, 32'h5A5A_0002}; wr_strb_q = '{4'hF, 4'hF};
    write_burst(1'b0, 10'h3FC, 1, 1, 0);
    read_burst(1'b0, 10'h000, 0, 0);
    checks++;
    if (rd_data_q.size() != 1 || rd_data_q[0] !== 32'h5A5A_0002) begin
      errors++; $display("FAIL wrap_word0: got %h expected 5a5a0002", (rd_data_q.size() > 0) ? rd_data_q[0] : 32'hX);
    end
    read_burst(1'b0, 10'h3FC, 1, 0);
    m = read_mismatch(10'h3FC, 1);
    checks++;
    if (m !== -1) begin errors++; $display("FAIL wrap_read: bad beat=%0d expected -1", m); end
    // Abandon a read burst with an asynchronous reset.
    S_AXI_ARID = 1'b1; S_AXI_ARADDR = 10'h100; S_AXI_ARLEN = 8'd7; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (S_AXI_ARREADY !== 1'b1 && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) timeouts++;
    @(negedge clk);
    S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_RLAST !== 1'b0) begin
      errors++; $display("FAIL mid_burst: rvalid/rlast got %b/%b expected 1/0", S_AXI_RVALID, S_AXI_RLAST);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (S_AXI_RVALID !== 1'b0 || S_AXI_RDATA !== 32'h0 || S_AXI_RLAST !== 1'b0) begin
      errors++; $display("FAIL async_reset: rvalid=%b rdata=%h rlast=%b expected 0/0/0", S_AXI_RVALID, S_AXI_RDATA, S_AXI_RLAST);
    end
    S_AXI_RREADY = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // The arbiter's history is cleared too, so a tie goes to write again.
    S_AXI_ARID = 1'b1; S_AXI_ARADDR = 10'h100; S_AXI_ARLEN = 8'd7; S_AXI_ARVALID = 1'b1;
    load_beats(1, 1'b0);
    write_burst(1'b1, 10'h200, 0, 0, 0);
    checks++;
    if (aw_lat !== 1 || aw_other !== 1'b0 || b_resp !== 2'b00) begin
      errors++; $display("FAIL post_reset_tie: aw_lat=%0d arready=%b bresp=%b expected 1/0/00", aw_lat, aw_other, b_resp);
    end
    read_burst(1'b1, 10'h100, 7, 0);
    m = read_mismatch(10'h100, 7);
    checks++;
    if (m !== -1 || r_id_seen !== 1'b1) begin
      errors++; $display("FAIL mem_after_reset: bad beat=%0d rid=%b expected -1/1", m, r_id_seen);
    end
  endtask

  task automatic test_random();
    int len, m, wl;
    logic [9:0] addr;
    logic [IDW-1:0] id;
    for (int t = 0; t < 24; t++) begin
      len = $urandom_range(0, 7);
      addr = 10'($urandom_range(0, 1023));
      id = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        load_beats(len + 1, 1'b1);
        wl = len;
        write_burst(id, addr, len, wl, $urandom_range(0, 3));
        checks++;
        if (b_resp !== 2'b00 || b_id !== id) begin
          errors++; $display("FAIL rand_write%0d: bresp/bid got %b/%b expected 00/%b", t, b_resp, b_id, id);
        end
      end else begin
        read_burst(id, addr, len, 2);
        m = read_mismatch(addr, len);
        checks++;
        if (m !== -1 || stall_bad !== 0 || r_id_seen !== id) begin
          errors++; $display("FAIL rand_read%0d: bad beat=%0d unstable=%0d rid=%b expected -1/0/%b", t, m, stall_bad, r_id_seen, id);
        end
      end
    end
  endtask

  initial begin
    S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    test_reset();
    test_fill();
    test_single();
    test_burst_strb();
    test_arbitration();
    test_wlast_errors();
    test_backpressure();
    test_wrap_reset();
    test_random();
    checks++;
    if (timeouts !== 0) begin errors++; $display("FAIL handshake_timeouts: got %0d expected 0", timeouts); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ethernet_axi_slave_mem.md
# ethernet_axi_slave_mem

AXI4 (full) memory-mapped slave that terminates the ethernet IP's burst-capable `m_axi` master port. It accepts write and read bursts and serves them from an internal word-addressed register memory. The bench or system interconnect no longer needs a VIP slave to close the loop on the master. One transaction is in flight at a time, and write/read contention is arbitrated round-robin.

## Interface
- C_S_AXI_ID_WIDTH, 1, width of AWID/BID/ARID/RID
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported
- C_S_AXI_ADDR_WIDTH, 10, byte-address width; memory depth = 2^(C_S_AXI_ADDR_WIDTH-2) words
- ACLK  in  1  clock, all logic rising-edge
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWID  in  ID_WIDTH  write ID, echoed on BID
- S_AXI_AWADDR  in  ADDR_WIDTH  burst start byte address; bits [1:0] ignored
- S_AXI_AWLEN  in  8  beats-1
- S_AXI_AWVALID  in  1  AW valid
- S_AXI_AWREADY  out  1  AW ready
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte enables
- S_AXI_WLAST  in  1  last write beat
- S_AXI_WVALID  in  1  W valid
- S_AXI_WREADY  out  1  W ready
- S_AXI_BID  out  ID_WIDTH  response ID
- S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
- S_AXI_BVALID  out  1  B valid
- S_AXI_BREADY  in  1  B ready
- S_AXI_ARID / S_AXI_ARADDR / S_AXI_ARLEN / S_AXI_ARVALID  in  as AW  read address channel
- S_AXI_ARREADY  out  1  AR ready
- S_AXI_RID  out  ID_WIDTH  read ID
- S_AXI_RDATA  out  32  read data; 0 whenever RVALID=0
- S_AXI_RRESP  out  2  always 00
- S_AXI_RLAST  out  1  last read beat
- S_AXI_RVALID  out  1  R valid
- S_AXI_RREADY  in  1  R ready

## Operation
- AWSIZE/ARSIZE are fixed at 4 bytes. Every burst is INCR. Burst type and size inputs are not present.
- The FSM has six states: IDLE, AW_ACK, WDATA, WRESP, AR_ACK, RDATA.
- IDLE is entered at reset and after each completed transaction.
- Arbitration in IDLE:
  - If only AWVALID is high, go to AW_ACK. If only ARVALID is high, go to AR_ACK.
  - If both are high, grant the side not served last. The "last served" flag resets to read, so write wins the first tie.
- AW_ACK / AR_ACK: assert AWREADY / ARREADY for exactly one cycle. Latch ID, word address = ADDR[ADDR_WIDTH-1:2] and LEN. Clear the beat counter.
- WDATA:
  - WREADY=1. Each WVALID&WREADY beat writes mem[addr] byte-wise per WSTRB, then increments addr and the beat counter.
  - The burst ends on the beat where WLAST=1 or beat counter=LEN, whichever comes first.
  - An error is flagged if WLAST and (counter==LEN) disagree on the ending beat.
  - All accepted beats are stored even when the error flag is set.
- WRESP: BVALID=1, BID=latched ID, BRESP=10 if error flagged, else 00. Hold until BREADY, then go to IDLE.
- RDATA:
  - RVALID=1, RDATA=mem[addr] (combinational from the registered address), RLAST=(counter==LEN), RID=latched ID.
  - On RVALID&RREADY, increment addr and counter. On the handshake with RLAST=1, go to IDLE.
- Address arithmetic: the word address wraps modulo memory depth (top word to word 0 inside a burst). No DECERR is generated.
- Memory is not reset. Its contents survive ARESETN. Power-up contents are undefined.

## Timing
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0. BRESP, RRESP, BID, RID, RDATA = 0.
- ARESETN low at any time: all outputs go to reset values asynchronously, FSM returns to IDLE, error flag and counters clear, and an in-progress burst is abandoned.
- Write latency:
  - AWVALID sampled in IDLE at cycle 0, AWREADY at cycle 1, WREADY from cycle 2.
  - One beat per cycle at full rate.
  - BVALID in the cycle after the ending beat.
- Read latency:
  - ARVALID at cycle 0, ARREADY at cycle 1, first RVALID at cycle 2.
  - Back-to-back beats at 1/cycle while RREADY=1.
  - RDATA/RLAST stay stable while RVALID=1 and RREADY=0.
- After a B or final R handshake there is one IDLE cycle before the next grant.
- A READY is never asserted for a channel that is not granted. VALID outputs never drop without a handshake (except on reset).

## Test plan
- Single write then single read: write 0xDEADBEEF to 0x010, WSTRB=F -> BRESP=00, BID echoed; read 0x010 -> RDATA=0xDEADBEEF, RLAST=1 on the only beat.
- 4-beat INCR burst: write 0x1,0x2,0x3,0x4 from 0x020, beat 2 with WSTRB=0x3 over preloaded 0xFFFFFFFF -> readback burst returns 0x1, 0x2, 0xFFFF0003, 0x4 with RLAST only on beat 3.
- Simultaneous AWVALID and ARVALID held for two transactions -> write granted first, then read. Next tie goes to write again (alternation).
- AWLEN=3 with WLAST on beat 1 -> two beats stored, BRESP=10. AWLEN=1 with no WLAST on beat 1 -> BRESP=10.
- Backpressure: RREADY toggled 1/0 per cycle and BREADY delayed 5 cycles -> RDATA/RLAST stable while stalled, no beats lost, BVALID held 5 cycles.
- Wrap and reset: 2-beat write at top word 0x3FC -> second beat lands at 0x000. ARESETN pulsed mid read burst -> RVALID=0 immediately, next transaction serviced normally, memory intact.
